// File: rtl/fir_window_builder.sv
// fir_window_builder: delay line that emits decimated symmetric FIR windows once full.
module fir_window_builder #(
  parameter int ADC_WIDTH = 16,
  parameter int NUM_TAPS  = 179,
  parameter int NUM_PAIRS = (NUM_TAPS - 1) / 2,
  parameter int DECIM     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clear,
  input  logic                           valid_in,
  input  logic [ADC_WIDTH-1:0]           sample_in,
  output logic [NUM_PAIRS*ADC_WIDTH-1:0] samples_a,
  output logic [NUM_PAIRS*ADC_WIDTH-1:0] samples_b,
  output logic [ADC_WIDTH-1:0]           sample_center,
  output logic                           valid_out,
  output logic                           filled,
  output logic [CNT_WIDTH-1:0]           fill_count
);
  localparam int LW = NUM_TAPS * ADC_WIDTH;
  localparam int PWW = NUM_PAIRS * ADC_WIDTH;
  localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
  typedef enum logic [1:0] {EMPTY, FILL, RUN} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] line_q, line_d;
  logic [PWW-1:0] a_q, a_d, b_q, b_d;
  logic [ADC_WIDTH-1:0] c_q, c_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic [PW-1:0] phase_q, phase_d, phase_inc;
  logic valid_q, accept, last_fill, emit;
  assign accept = valid_in & ~clear;
  assign last_fill = accept && state_q != RUN && count_q == CNT_WIDTH'(NUM_TAPS - 1);
  assign phase_inc = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
  assign emit = last_fill | (accept && state_q == RUN && phase_inc == '0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (clear) state_d = EMPTY;
    else if (accept && state_q != RUN) state_d = last_fill ? RUN : FILL;
  end
  always_comb filled = (state_q == RUN);
  // Window slices are taken from the post-shift line so the accepted sample lands in tap 0.
  always_comb begin
    line_d = clear ? '0 : accept ? {line_q[LW-ADC_WIDTH-1:0], sample_in} : line_q;
    count_d = clear ? '0 : (accept && count_q != CNT_WIDTH'(NUM_TAPS)) ? count_q + 1'b1 : count_q;
    phase_d = (clear || last_fill) ? '0 : (accept && state_q == RUN) ? phase_inc : phase_q;
    a_d = '0;
    b_d = '0;
    for (int j = 0; j < NUM_PAIRS; j++) begin
      a_d[j*ADC_WIDTH +: ADC_WIDTH] = line_d[j*ADC_WIDTH +: ADC_WIDTH];
      b_d[j*ADC_WIDTH +: ADC_WIDTH] = line_d[(NUM_TAPS-1-j)*ADC_WIDTH +: ADC_WIDTH];
    end
    c_d = line_d[NUM_PAIRS*ADC_WIDTH +: ADC_WIDTH];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q  <= '0;
      count_q <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
    end else begin
      line_q  <= line_d;
      count_q <= count_d;
      phase_q <= phase_d;
      valid_q <= emit;
      if (clear) begin
        a_q <= '0;
        b_q <= '0;
        c_q <= '0;
      end else if (emit) begin
        a_q <= a_d;
        b_q <= b_d;
        c_q <= c_d;
      end
    end
  end
  assign samples_a = a_q;
  assign samples_b = b_q;
  assign sample_center = c_q;
  assign valid_out = valid_q;
  assign fill_count = count_q;
endmodule

// File: tb/tb_fir_window_builder.sv
// tb_fir_window_builder: directed checks of fill, decimation, bubbles, clear, async reset and extremes.
module tb_fir_window_builder;
  localparam int W = 16;
  localparam int NT = 179;
  localparam int NP = 89;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0, valid_in = 1'b0;
  logic [W-1:0] sample_in = '0;
  logic [NP*W-1:0] samples_a, samples_b;
  logic [W-1:0] sample_center;
  logic valid_out, filled;
  logic [7:0] fill_count;
  int n_cmp = 0, n_bad = 0, strobes;
  fir_window_builder #(.ADC_WIDTH(W), .NUM_TAPS(NT), .NUM_PAIRS(NP), .DECIM(2), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .valid_in(valid_in), .sample_in(sample_in),
    .samples_a(samples_a), .samples_b(samples_b), .sample_center(sample_center),
    .valid_out(valid_out), .filled(filled), .fill_count(fill_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W-1:0] sa(input int j);
    return samples_a[j*W +: W];
  endfunction
  function automatic logic [W-1:0] sb(input int j);
    return samples_b[j*W +: W];
  endfunction
  task automatic push(input logic [W-1:0] v);
    valid_in = 1'b1;
    sample_in = v;
    @(negedge clk);
    valid_in = 1'b0;
  endtask
  task automatic idle();
    valid_in = 1'b0;
    @(negedge clk);
  endtask
  task automatic fill(input int n, input bit bubble);
    strobes = 0;
    for (int k = 1; k <= n; k++) begin
      push(W'(k));
      if (k < n) begin
        strobes += int'(valid_out);
        if (bubble) begin
          idle();
          strobes += int'(valid_out);
        end
      end
    end
  endtask
  task automatic check_window179(input string tag);
    check({tag, " early"}, strobes, 0);
    check({tag, " vout"}, valid_out, 1);
    check({tag, " filled"}, filled, 1);
    check({tag, " count"}, fill_count, NT);
    check({tag, " a0"}, sa(0), 179);
    check({tag, " b0"}, sb(0), 1);
    check({tag, " a88"}, sa(88), 91);
    check({tag, " b88"}, sb(88), 89);
    check({tag, " ctr"}, sample_center, 90);
  endtask
  task automatic check_zero(input string tag);
    check({tag, " count"}, fill_count, 0);
    check({tag, " filled"}, filled, 0);
    check({tag, " vout"}, valid_out, 0);
    check({tag, " a0s"}, samples_a == '0, 1);
    check({tag, " b0s"}, samples_b == '0, 1);
    check({tag, " ctr"}, sample_center, 0);
  endtask
  initial begin
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(NT, 1'b0);
    check_window179("ramp");
    push(16'd180);
    check("dec180 vout", valid_out, 0);
    check("dec180 hold", sa(0), 179);
    idle();
    check("gap hold", sa(0), 179);
    push(16'd181);
    check("dec181 vout", valid_out, 1);
    check("dec181 a0", sa(0), 181);
    check("dec181 b0", sb(0), 3);
    check("dec181 ctr", sample_center, 92);
    idle();
    check("post vout", valid_out, 0);
    check("post hold", sa(0), 181);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check_zero("clr run");
    fill(100, 1'b0);
    check("mid count", fill_count, 100);
    clear = 1'b1;
    push(16'd999);
    clear = 1'b0;
    check_zero("clr fill");
    fill(NT, 1'b1);
    check_window179("bubble");
    idle();
    check("bub gap vout", valid_out, 0);
    push(16'd180);
    check("bub180 vout", valid_out, 0);
    idle();
    push(16'd181);
    check("bub181 vout", valid_out, 1);
    check("bub181 a0", sa(0), 181);
    check("bub181 b0", sb(0), 3);
    check("bub181 ctr", sample_center, 92);
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    @(negedge clk);
    rst_n = 1'b1;
    fill(NT, 1'b0);
    check_window179("refill");
    clear = 1'b1;
    idle();
    clear = 1'b0;
    for (int k = 1; k <= NT; k++) push((k % 2) ? 16'h8000 : 16'h7FFF);
    check("ext vout", valid_out, 1);
    for (int j = 0; j < NP; j++) begin
      check($sformatf("ext a%0d", j), sa(j), (j % 2 == 0) ? 32'h8000 : 32'h7FFF);
      check($sformatf("ext b%0d", j), sb(j), (j % 2 == 0) ? 32'h8000 : 32'h7FFF);
    end
    check("ext ctr", sample_center, 16'h7FFF);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fir_window_builder.md
# fir_window_builder

Streaming front end for the symmetric FIR layer. It accepts one ADC sample per valid cycle into a NUM_TAPS-deep delay line. Once the line is full, it presents the symmetric tap pairs and the centre tap as flattened vectors, decimating by DECIM for the wavelet decomposition stage. Its outputs connect directly to the FIR layer's `samples_a`, `samples_b`, `sample_center` and `valid_in`.

## Interface
- ADC_WIDTH, 16, sample width (signed Q16.0)
- NUM_TAPS, 179, filter length (odd)
- NUM_PAIRS, (NUM_TAPS-1)/2 = 89, symmetric pairs
- DECIM, 2, output decimation factor (≥1)
- CNT_WIDTH, 8, fill counter width (≥ clog2(NUM_TAPS+1))
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of delay line and counters
- valid_in  in  1  sample_in valid this cycle
- sample_in  in  ADC_WIDTH  signed ADC sample
- samples_a  out  NUM_PAIRS*ADC_WIDTH  slice j = tap[j] (newest side)
- samples_b  out  NUM_PAIRS*ADC_WIDTH  slice j = tap[NUM_TAPS-1-j] (oldest side)
- sample_center  out  ADC_WIDTH  tap[NUM_PAIRS]
- valid_out  out  1  one-cycle window strobe
- filled  out  1  delay line full (state RUN)
- fill_count  out  CNT_WIDTH  accepted samples, saturates at NUM_TAPS

## Operation
- Delay line tap[0..NUM_TAPS-1], tap[0] newest. On an accepted sample (valid_in=1, clear=0): tap[k] <= tap[k-1], tap[0] <= sample_in. Values pass bit-exact with no arithmetic.
- FSM:
  - EMPTY (fill_count=0) -> FILL on the first accept.
  - FILL -> RUN on the accept that brings fill_count to NUM_TAPS.
  - RUN holds until clear or reset.
  - clear from any state -> EMPTY.
- Phase counter 0..DECIM-1:
  - Set to 0 on the FILL->RUN accept.
  - In RUN, advances on each accept and wraps DECIM-1 -> 0.
- A window is emitted on the FILL->RUN accept and on every RUN accept where the post-increment phase is 0. So windows are emitted at accepted samples NUM_TAPS, NUM_TAPS+DECIM, NUM_TAPS+2·DECIM, …
- Emit:
  - samples_a, samples_b and sample_center are registered from the post-shift tap contents.
  - valid_out pulses for one cycle.
- Window outputs hold their last emitted value between strobes.
- No backpressure. The downstream FIR accepts every cycle.
- valid_in gaps of any length are allowed. Phase and count change only on accepts.
- clear:
  - Zeroes all taps, fill_count, phase and the window registers.
  - valid_out is 0 in the next cycle.
  - clear wins over a same-cycle valid_in, and that sample is discarded.
- fill_count saturates at NUM_TAPS. It never wraps.

## Timing
- Reset (rst_n=0, asynchronous assert): every tap, window output, valid_out, filled, fill_count and phase is 0, and the FSM is in EMPTY. Deassertion is synchronised externally.
- Latency: valid_out and the new window appear on the clock edge after the accepting edge (1 cycle).
- filled rises on the same edge that fill_count becomes NUM_TAPS, which is also the first valid_out edge.
- Strobe spacing in RUN equals the time taken to accept DECIM samples. Back-to-back valid_in with DECIM=2 gives valid_out every 2nd cycle.
- DECIM=1: valid_out follows every accept in RUN, one cycle later.
- Reset mid-operation discards all contents. Refill requires NUM_TAPS new accepts.

## Test plan
- **Ramp fill, DECIM=2:** feed sample_in = 1..179 back-to-back -> no valid_out before sample 179. One cycle after sample 179: valid_out=1, filled=1, fill_count=179, a[0]=179, b[0]=1, a[88]=91, b[88]=89, center=90.
- **Decimation:** continue with 180, 181 -> no strobe after 180. Strobe after 181 with a[0]=181, b[0]=3, center=92. Outputs stay unchanged during the gap.
- **Bubbles:** same ramp with valid_in toggling 1/0 -> identical windows and counts. Strobes land one cycle after the accepts of 179, 181, ….
- **Clear mid-fill:** clear at fill_count=100, asserted together with valid_in=1 -> next cycle fill_count=0, filled=0 and all taps read 0. The sample is dropped, and the next 179 accepts produce the first strobe.
- **Async reset in RUN:** pulse rst_n low mid-cycle -> all outputs are 0 immediately, with no valid_out until 179 further accepts.
- **Sign/extremes:** fill with 0x8000 and 0x7FFF alternating -> the window slices reproduce the exact bit patterns at the expected tap positions.
